// File: rtl/sseg_pkg.sv
// Shared definitions for the occupancy display: segment codes, converter
// states, anode selects and the digit-to-segment helper.
package sseg_pkg;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_E     = 8'h86;
  localparam logic [7:0] SEG_A     = 8'h88;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [3:0] AN_UNITS  = 4'b1110;
  localparam logic [3:0] AN_TENS   = 4'b1101;
  localparam logic [3:0] AN_HUNDS  = 4'b1011;
  localparam logic [3:0] AN_STATUS = 4'b0111;
  localparam logic [3:0] AN_OFF    = 4'b1111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

  function automatic logic [7:0] seg_of_digit(input logic [3:0] digit);
    case (digit)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bcd_converter.sv
// Sequential double-dabble: converts an 8-bit value to three BCD digits,
// one shift per cycle, and reconverts only when the input differs from the last result.
module bcd_converter
  import sseg_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] i_value,
  output logic [3:0] o_hundreds,
  output logic [3:0] o_tens,
  output logic [3:0] o_units,
  output logic       o_busy,
  output logic       o_done
);

  conv_state_t r_state;
  logic [19:0] r_shift;
  logic [2:0]  r_iter;
  logic [7:0]  r_snap;
  logic [7:0]  r_last;
  logic [19:0] w_adj;

  always_comb begin
    w_adj = r_shift;
    if (r_shift[11:8]  >= 4'd5) w_adj[11:8]  = r_shift[11:8]  + 4'd3;
    if (r_shift[15:12] >= 4'd5) w_adj[15:12] = r_shift[15:12] + 4'd3;
    if (r_shift[19:16] >= 4'd5) w_adj[19:16] = r_shift[19:16] + 4'd3;
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values,
  // which keeps the shift and the iteration count in lockstep.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_iter  <= '0;
      r_snap  <= '0;
      r_last  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_value != r_last) begin
            r_shift <= {12'd0, i_value};
            r_snap  <= i_value;
            r_iter  <= '0;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_shift <= {w_adj[18:0], 1'b0};
          r_iter  <= r_iter + 3'd1;
          if (r_iter == 3'd7) r_state <= DONE;
        end
        DONE: begin
          r_last  <= r_snap;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_hundreds = r_shift[19:16];
  assign o_tens     = r_shift[15:12];
  assign o_units    = r_shift[11:8];
  assign o_busy     = (r_state == SHIFT);
  assign o_done     = (r_state == DONE);

endmodule

// File: rtl/sseg_occupancy_display.sv
// Four-digit multiplexed 7-segment display of occupancy plus a water-level status digit.
// Optional emergency blink of all segments is enabled by defining SSEG_BLINK_EN.
module sseg_occupancy_display
  import sseg_pkg::*;
#(
  parameter int REFRESH_BITS = 18,
  parameter int BLINK_BITS   = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] occupancy,
  input  logic       alerta,
  input  logic       emergencia,
  output logic [7:0] sseg,
  output logic [3:0] an
);

  if (REFRESH_BITS < 3) begin : g_bad_refresh
    $error("REFRESH_BITS must be at least 3");
  end
  if (BLINK_BITS < 2) begin : g_bad_blink
    $error("BLINK_BITS must be at least 2");
  end

  logic [REFRESH_BITS-1:0] r_scan_cnt;
  logic [3:0] r_hundreds, r_tens, r_units;
  logic [7:0] r_sseg;
  logic [3:0] r_an;

  logic [3:0] w_conv_hundreds, w_conv_tens, w_conv_units;
  logic       w_conv_busy, w_conv_done;
  logic [1:0] w_idx;
  logic [3:0] w_an_next;
  logic [7:0] w_sseg_next;
  logic       w_force_blank;

  bcd_converter u_bcd (
    .clk        (clk),
    .reset      (reset),
    .i_value    (occupancy),
    .o_hundreds (w_conv_hundreds),
    .o_tens     (w_conv_tens),
    .o_units    (w_conv_units),
    .o_busy     (w_conv_busy),
    .o_done     (w_conv_done)
  );

`ifdef SSEG_BLINK_EN
  logic [BLINK_BITS-1:0] r_blink_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_blink_cnt <= '0;
    else       r_blink_cnt <= r_blink_cnt + 1'b1;
  end

  assign w_force_blank = emergencia & r_blink_cnt[BLINK_BITS-1];
`else
  assign w_force_blank = 1'b0;
`endif

  assign w_idx = r_scan_cnt[REFRESH_BITS-1:REFRESH_BITS-2];

  // NOTE: every output of this block is assigned a default first, so no path
  // through the case can leave a latch behind.
  always_comb begin
    w_an_next   = AN_OFF;
    w_sseg_next = SEG_BLANK;
    case (w_idx)
      2'd0: begin
        w_an_next   = AN_UNITS;
        w_sseg_next = seg_of_digit(r_units);
      end
      2'd1: begin
        w_an_next = AN_TENS;
        if (r_hundreds != 4'd0 || r_tens != 4'd0) w_sseg_next = seg_of_digit(r_tens);
      end
      2'd2: begin
        w_an_next = AN_HUNDS;
        if (r_hundreds != 4'd0) w_sseg_next = seg_of_digit(r_hundreds);
      end
      default: begin
        w_an_next = AN_STATUS;
        if (emergencia)  w_sseg_next = SEG_E;
        else if (alerta) w_sseg_next = SEG_A;
      end
    endcase
    if (w_force_blank) w_sseg_next = SEG_BLANK;
  end

  // Display digits change only on a completed conversion, all three at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_scan_cnt <= '0;
      r_hundreds <= '0;
      r_tens     <= '0;
      r_units    <= '0;
      r_an       <= AN_OFF;
      r_sseg     <= SEG_BLANK;
    end else begin
      r_scan_cnt <= r_scan_cnt + 1'b1;
      if (w_conv_done && !w_conv_busy) begin
        r_hundreds <= w_conv_hundreds;
        r_tens     <= w_conv_tens;
        r_units    <= w_conv_units;
      end
      r_an   <= w_an_next;
      r_sseg <= w_sseg_next;
    end
  end

  assign an   = r_an;
  assign sseg = r_sseg;

endmodule

// File: tb/tb_sseg_occupancy_display.sv
// Directed bench for sseg_occupancy_display with a short scan period (REFRESH_BITS=4).
// Honours SSEG_BLINK_EN when the same macro is given to the bench build.
module tb_sseg_occupancy_display;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] occupancy;
  logic       alerta;
  logic       emergencia;
  logic [7:0] sseg;
  logic [3:0] an;

  int checks   = 0;
  int failures = 0;

  // Segment byte seen per digit during the last frame: 0=units 1=tens 2=hundreds 3=status.
  logic [7:0] seg_seen [4];
  int         onehot_err;
  int         blank_cycles;

  sseg_occupancy_display #(.REFRESH_BITS(4), .BLINK_BITS(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .occupancy  (occupancy),
    .alerta     (alerta),
    .emergencia (emergencia),
    .sseg       (sseg),
    .an         (an)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // One full scan (16 cycles) sampled on falling edges.
  task automatic capture_frame();
    for (int d = 0; d < 4; d++) seg_seen[d] = 8'h00;
    onehot_err   = 0;
    blank_cycles = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (sseg == 8'hFF) blank_cycles++;
      case (an)
        4'b1110: seg_seen[0] = sseg;
        4'b1101: seg_seen[1] = sseg;
        4'b1011: seg_seen[2] = sseg;
        4'b0111: seg_seen[3] = sseg;
        default: onehot_err++;
      endcase
    end
  endtask

  task automatic check_frame(input string tag, input logic [7:0] e_hund, input logic [7:0] e_tens,
                             input logic [7:0] e_units, input logic [7:0] e_stat);
    capture_frame();
    check({tag, ".onehot"}, onehot_err, 0);
    check({tag, ".hund"},   seg_seen[2], e_hund);
    check({tag, ".tens"},   seg_seen[1], e_tens);
    check({tag, ".units"},  seg_seen[0], e_units);
    check({tag, ".status"}, seg_seen[3], e_stat);
  endtask

  logic [3:0] an_exp [4];

  initial begin
    an_exp[0] = 4'b1110;
    an_exp[1] = 4'b1101;
    an_exp[2] = 4'b1011;
    an_exp[3] = 4'b0111;

    reset      = 1'b1;
    occupancy  = 8'd0;
    alerta     = 1'b0;
    emergencia = 1'b0;
    repeat (2) @(negedge clk);
    check("rst.an", an, 4'hF);
    check("rst.sseg", sseg, 8'hFF);

    // Scan order straight out of reset: each anode held 4 cycles.
    reset = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      check($sformatf("scan[%0d]", k), an, an_exp[k / 4]);
    end

    // Asynchronous reset in the middle of a scan period.
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst.an", an, 4'hF);
    check("midrst.sseg", sseg, 8'hFF);
    @(negedge clk);
    reset = 1'b0;
    check_frame("zero", 8'hFF, 8'hFF, 8'hC0, 8'hFF);

    occupancy = 8'd137;
    repeat (12) @(negedge clk);
    check_frame("v137", 8'hF9, 8'hB0, 8'hF8, 8'hFF);

    // Change while the 50 conversion is still shifting.
    occupancy = 8'd50;
    repeat (3) @(negedge clk);
    occupancy = 8'd51;
    repeat (25) @(negedge clk);
    check_frame("v51", 8'hFF, 8'h92, 8'hF9, 8'hFF);

    occupancy = 8'd255;
    repeat (12) @(negedge clk);
    check_frame("v255", 8'hA4, 8'h92, 8'h92, 8'hFF);

    // Reset lands while converting 100; input returns to 0 so the digits stay 000.
    occupancy = 8'd100;
    repeat (3) @(negedge clk);
    reset     = 1'b1;
    occupancy = 8'd0;
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    check_frame("abort", 8'hFF, 8'hFF, 8'hC0, 8'hFF);

    occupancy = 8'd188;
    alerta    = 1'b1;
    repeat (12) @(negedge clk);
    check_frame("alerta", 8'hF9, 8'h80, 8'h80, 8'h88);

    emergencia = 1'b1;
    @(negedge clk);
    capture_frame();
    check("emerg.onehot", onehot_err, 0);
`ifdef SSEG_BLINK_EN
    check("emerg.blank_cycles", blank_cycles, 8);
`else
    check("emerg.status", seg_seen[3], 8'h86);
    check("emerg.blank_cycles", blank_cycles, 0);
`endif

    emergencia = 1'b0;
    @(negedge clk);
    check_frame("resume", 8'hF9, 8'h80, 8'h80, 8'h88);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
